// File: rtl/img_sram_pkg.sv
// Shared types for the image SRAM and its readback controller.
package img_sram_pkg;

    localparam int unsigned IMG_DIM_W = 8;
    localparam int unsigned IMG_IDX_W = 9;

    // SRAM control bundle driven by both the write path and readback.
    typedef struct packed {
        logic                 sense_en;
        logic                 write_en;
        logic [IMG_DIM_W-1:0] row;
        logic [IMG_DIM_W-1:0] col;
        logic [7:0]           din;
    } img_sram_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } tx_state_t;

endpackage

// File: rtl/io_tx_fifo.sv
// Small synchronous FIFO holding {pixel, last} words ahead of the tx port.
module io_tx_fifo
    import img_sram_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         head_vld,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Occupancy update; push and pop together leave the count unchanged.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage, pointers and a registered non-empty flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_vld <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count    <= count_nxt;
            head_vld <= (count_nxt != '0);
        end
    end

endmodule

// File: rtl/io_tx_controller.sv
// Raster-order image readback from SRAM onto a valid/ready byte stream.
module io_tx_controller
    import img_sram_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = RD_LAT + 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [7:0]     nrows,
    input  logic [7:0]     ncols,
    input  logic [7:0]     sram_dout,
    output img_sram_ctrl_t sram_ctrl,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    output logic           tx_last,
    input  logic           tx_ready,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 1;

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [IMG_IDX_W-1:0] row_idx;
    logic [IMG_IDX_W-1:0] col_idx;
    logic [IMG_IDX_W-1:0] nrows_q;
    logic [IMG_IDX_W-1:0] ncols_q;
    logic [RD_LAT-1:0]    pipe_vld;
    logic [RD_LAT-1:0]    pipe_last;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     inflight_cnt;
    logic [IMG_DIM_W:0]   fifo_head;
    logic                 credit;
    logic                 last_addr;
    logic                 issue;
    logic                 push;
    logic                 pop;

    assign last_addr = (row_idx == nrows_q) && (col_idx == ncols_q);
    assign credit    = (CRD_W'(fifo_count) + CRD_W'(inflight_cnt)) < CRD_W'(FIFO_DEPTH);
    assign issue     = (state == ISSUE) && credit;
    assign push      = pipe_vld[RD_LAT-1];
    assign pop       = tx_valid && tx_ready;
    assign tx_data   = fifo_head[IMG_DIM_W:1];
    assign tx_last   = fifo_head[0];

    assign sram_ctrl.sense_en = 1'b1;
    assign sram_ctrl.write_en = 1'b0;
    assign sram_ctrl.row      = row_idx[IMG_DIM_W-1:0];
    assign sram_ctrl.col      = col_idx[IMG_DIM_W-1:0];
    assign sram_ctrl.din      = '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DRAIN ends on acceptance of the final tagged byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (issue && last_addr) state_nxt = DRAIN;
            DRAIN:   if (pop && tx_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered status outputs, aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            done <= (state_nxt == DONE);
        end
    end

    // Dimension latch and raster address counters; address holds without a credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx <= '0;
            col_idx <= '0;
            nrows_q <= '0;
            ncols_q <= '0;
        end else if ((state == IDLE) && start) begin
            row_idx <= '0;
            col_idx <= '0;
            nrows_q <= IMG_IDX_W'(nrows);
            ncols_q <= IMG_IDX_W'(ncols);
        end else if (issue && !last_addr) begin
            if (col_idx == ncols_q) begin
                col_idx <= '0;
                row_idx <= row_idx + IMG_IDX_W'(1);
            end else begin
                col_idx <= col_idx + IMG_IDX_W'(1);
            end
        end
    end

    // Read-tag pipe matching SRAM latency, plus count of reads in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld     <= '0;
            pipe_last    <= '0;
            inflight_cnt <= '0;
        end else begin
            pipe_vld[0]  <= issue;
            pipe_last[0] <= issue && last_addr;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            case ({issue, push})
                2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    io_tx_fifo #(
        .WIDTH (IMG_DIM_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({sram_dout, pipe_last[RD_LAT-1]}),
        .pop       (pop),
        .head      (fifo_head),
        .head_vld  (tx_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_io_tx_controller.sv
// Directed bench for io_tx_controller with an SRAM model and stream scoreboard.
module tb_io_tx_controller;
    import img_sram_pkg::*;

    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = RD_LAT + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [7:0]     nrows;
    logic [7:0]     ncols;
    logic [7:0]     sram_dout;
    img_sram_ctrl_t sram_ctrl;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_last;
    logic           tx_ready = 1'b0;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // scoreboard state
    int       exp_nr, exp_nc, exp_r, exp_c;
    int       n_acc, n_last, first_vld_cyc, first_acc, last_acc, max_cnt;
    int       s_cyc, done_cyc;
    int       rdy_mode = 0;
    bit       mon_en = 1'b0;
    bit       hold_prev;
    logic [8:0] hold_word;
    logic [7:0] sram_pipe [RD_LAT];

    io_tx_controller #(.RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .nrows     (nrows),
        .ncols     (ncols),
        .sram_dout (sram_dout),
        .sram_ctrl (sram_ctrl),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 16 + c) ^ 8'(r >> 4);
    endfunction

    // SRAM read model: data appears RD_LAT cycles after the address.
    always @(posedge clk) begin
        sram_pipe[0] <= pix(int'(sram_ctrl.row), int'(sram_ctrl.col));
        for (int i = 1; i < RD_LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign sram_dout = sram_pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_clear(input int nr, input int nc);
        exp_nr = nr; exp_nc = nc; exp_r = 0; exp_c = 0;
        n_acc = 0; n_last = 0; first_vld_cyc = -1; first_acc = -1; last_acc = -1;
        max_cnt = 0; hold_prev = 1'b0;
    endtask

    task automatic start_img(input int nr, input int nc);
        nrows = 8'(nr); ncols = 8'(nc); start = 1'b1; s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        done_cyc = cyc;
    endtask

    // Consumer: drives tx_ready, checks order, last flag and hold stability.
    always @(negedge clk) begin
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
        if (mon_en && !rst) begin
            if (hold_prev) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_word", 32'({tx_data, tx_last}), 32'(hold_word));
            end
            if (tx_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (tx_valid && tx_ready) begin
                check("data", 32'(tx_data), 32'(pix(exp_r, exp_c)));
                check("last", 32'(tx_last), 32'(exp_r == exp_nr && exp_c == exp_nc));
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
                if (tx_last) n_last++;
                if (exp_c == exp_nc) begin
                    exp_c = 0;
                    exp_r++;
                end else begin
                    exp_c++;
                end
            end
            hold_prev = tx_valid && !tx_ready;
            hold_word = {tx_data, tx_last};
            if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
        end
    end

    initial begin
        #1_500_000;
        bad++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; nrows = '0; ncols = '0;
        sb_clear(0, 0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_last", 32'(tx_last), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_ctrl", 32'(sram_ctrl), 32'({1'b1, 1'b0, 8'd0, 8'd0, 8'd0}));
        rst = 1'b0;
        @(negedge clk);

        // 2x3 image, ready held high
        sb_clear(1, 2); mon_en = 1'b1; rdy_mode = 0;
        start_img(1, 2);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_addr", 32'({sram_ctrl.row, sram_ctrl.col}), 32'd0);
        wait_done(100);
        check("t1_latency", 32'(first_vld_cyc - s_cyc), 32'd3);
        check("t1_count", 32'(n_acc), 32'd6);
        check("t1_nlast", 32'(n_last), 32'd1);
        check("t1_burst", 32'(last_acc - first_acc), 32'd5);
        check("t1_done_cyc", 32'(done_cyc - last_acc), 32'd1);
        check("t1_busy_off", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);

        // 1x1 image; start coincident with done is ignored
        sb_clear(0, 0);
        start_img(0, 0);
        wait_done(50);
        check("t2_count", 32'(n_acc), 32'd1);
        check("t2_nlast", 32'(n_last), 32'd1);
        nrows = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t2_start_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("t2_still_idle", 32'(busy), 32'd0);
        check("t2_no_valid", 32'(tx_valid), 32'd0);

        // 4x4 image, random backpressure
        sb_clear(3, 3); rdy_mode = 1;
        start_img(3, 3);
        wait_done(500);
        check("t3_count", 32'(n_acc), 32'd16);
        check("t3_fifo_bound", 32'(max_cnt <= FIFO_DEPTH), 32'd1);
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        // 4x8 image, ready low for 20 cycles: issue stalls after FIFO_DEPTH reads
        sb_clear(3, 7); rdy_mode = 2;
        start_img(3, 7);
        repeat (19) @(negedge clk);
        check("t4_stall_col", 32'(sram_ctrl.col), 32'(FIFO_DEPTH));
        check("t4_stall_row", 32'(sram_ctrl.row), 32'd0);
        check("t4_head_valid", 32'(tx_valid), 32'd1);
        check("t4_head_data", 32'(tx_data), 32'(pix(0, 0)));
        check("t4_none_taken", 32'(n_acc), 32'd0);
        rdy_mode = 0;
        wait_done(200);
        check("t4_count", 32'(n_acc), 32'd32);
        check("t4_no_gaps", 32'(last_acc - first_acc), 32'd31);
        repeat (2) @(negedge clk);

        // restart request while busy is ignored
        sb_clear(2, 3);
        start_img(2, 3);
        repeat (4) @(negedge clk);
        start_img(5, 5);
        wait_done(200);
        check("t5_count", 32'(n_acc), 32'd12);
        check("t5_nlast", 32'(n_last), 32'd1);
        repeat (2) @(negedge clk);

        // reset mid-stream, then a fresh start from (0,0)
        sb_clear(3, 3);
        start_img(3, 3);
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_valid", 32'(tx_valid), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_quiet", 32'(tx_valid), 32'd0);
        sb_clear(1, 2); mon_en = 1'b1;
        start_img(1, 2);
        wait_done(100);
        check("t6_count", 32'(n_acc), 32'd6);
        check("t6_latency", 32'(first_vld_cyc - s_cyc), 32'd3);
        repeat (2) @(negedge clk);

        // full 256x256 image
        sb_clear(255, 255);
        start_img(255, 255);
        wait_done(70000);
        check("t7_count", 32'(n_acc), 32'd65536);
        check("t7_nlast", 32'(n_last), 32'd1);
        @(negedge clk);
        check("t7_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
